// File: rtl/fs_nms_filter.sv
// ---------------------------------------------------------------------------
// fs_nms_filter
//
// 3x3 non-maximum suppression on the raster-ordered FAST corner score
// stream. Two score line buffers plus a two-column window register set form
// the 3x3 neighbourhood around pixel (r-1,c-1) whenever pixel (r,c) is
// accepted. Centers that survive suppression are pushed, with their pixel
// address, into a first-word-fall-through output FIFO.
//
// Optional build macro: FS_NMS_SCORE_THRESH_EN
//   When defined, adds input min_score. A survivor must also have
//   S >= min_score. The threshold is captured at frame_start.
//
// Ports
//   clk          single clock, rising edge
//   reset_n      asynchronous active-low reset
//   frame_start  pulse with the first pixel (row 0, col 0) of a frame
//   in_valid     in_score / in_addr valid this cycle
//   in_score     corner score, 0 = not a corner
//   in_addr      pixel address of in_score
//   min_score    (FS_NMS_SCORE_THRESH_EN only) minimum survivor score
//   out_valid    FIFO non-empty
//   out_ready    consumer pops the head when out_valid & out_ready
//   out_score    head entry score (holds last value when empty)
//   out_addr     head entry address (holds last value when empty)
//   overflow     sticky: a survivor was dropped on a full FIFO
//   frame_done   one-cycle pulse after the last center of a frame
// ---------------------------------------------------------------------------
module fs_nms_filter #(
    parameter int IMG_W      = 180,
    parameter int IMG_H      = 120,
    parameter int SCORE_W    = 12,
    parameter int ADDR_W     = 15,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               frame_start,
    input  logic               in_valid,
    input  logic [SCORE_W-1:0] in_score,
    input  logic [ADDR_W-1:0]  in_addr,
`ifdef FS_NMS_SCORE_THRESH_EN
    input  logic [SCORE_W-1:0] min_score,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SCORE_W-1:0] out_score,
    output logic [ADDR_W-1:0]  out_addr,
    output logic               overflow,
    output logic               frame_done
);

    localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW   = $clog2(IMG_H + 1);
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW = PW + 1;

    localparam logic [CW-1:0]     COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0]     ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [RW-1:0]     ROW_END   = RW'(IMG_H);
    localparam logic [CNTW-1:0]   FIFO_FULL = CNTW'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_OFS  = ADDR_W'(IMG_W + 1);

    // -----------------------------------------------------------------------
    // Position counters, line buffers and window
    // -----------------------------------------------------------------------
    logic [CW-1:0]      col_q, col_d;
    logic [RW-1:0]      row_q, row_d;
    logic [CW-1:0]      cur_col;
    logic [RW-1:0]      cur_row;
    logic               accept;

    // lb_prev_q holds row r-1, lb_prev2_q holds row r-2, indexed by column.
    logic [SCORE_W-1:0] lb_prev_q  [IMG_W];
    logic [SCORE_W-1:0] lb_prev2_q [IMG_W];
    logic [SCORE_W-1:0] lb_prev;
    logic [SCORE_W-1:0] lb_prev2;

    // Window columns c-2 (a) and c-1 (b); index 0 = row r-2, 1 = r-1, 2 = r.
    logic [2:0][SCORE_W-1:0] win_a_q;
    logic [2:0][SCORE_W-1:0] win_b_q;

    logic [SCORE_W-1:0] center;
    logic               earlier_ok;
    logic               later_ok;
    logic               thresh_ok;
    logic               eval_en;
    logic               survivor;
    logic [ADDR_W-1:0]  center_addr;
    logic               frame_done_d;

    // frame_start overrides the counters for the pixel it arrives with.
    assign cur_col  = frame_start ? '0 : col_q;
    assign cur_row  = frame_start ? '0 : row_q;
    assign accept   = in_valid && (cur_row < ROW_END);

    assign lb_prev  = lb_prev_q[cur_col];
    assign lb_prev2 = lb_prev2_q[cur_col];

    assign center   = win_b_q[1];

    // Strict against raster-earlier neighbours, non-strict against later
    // ones: the first pixel of a plateau wins, the rest are suppressed.
    assign earlier_ok = (center > win_a_q[0]) && (center > win_b_q[0]) &&
                        (center > lb_prev2)   && (center > win_a_q[1]);
    assign later_ok   = (center >= lb_prev)   && (center >= win_a_q[2]) &&
                        (center >= win_b_q[2]) && (center >= in_score);

`ifdef FS_NMS_SCORE_THRESH_EN
    logic [SCORE_W-1:0] min_score_q;
    assign thresh_ok = (center >= min_score_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            min_score_q <= '0;
        end else if (frame_start) begin
            min_score_q <= min_score;
        end
    end
`else
    assign thresh_ok = 1'b1;
`endif

    // c >= 2 keeps the window from straddling the line wrap.
    assign eval_en     = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    assign survivor    = eval_en && (center != '0) && earlier_ok && later_ok && thresh_ok;
    assign center_addr = in_addr - ADDR_OFS;

    assign frame_done_d = accept && (cur_row == ROW_LAST) && (cur_col == COL_LAST);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q      <= '0;
            row_q      <= '0;
            win_a_q    <= '0;
            win_b_q    <= '0;
            frame_done <= 1'b0;
            for (int i = 0; i < IMG_W; i++) begin
                lb_prev_q[i]  <= '0;
                lb_prev2_q[i] <= '0;
            end
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            frame_done <= frame_done_d;
            if (accept) begin
                lb_prev_q[cur_col]  <= in_score;
                lb_prev2_q[cur_col] <= lb_prev;
                win_a_q             <= win_b_q;
                win_b_q             <= {in_score, lb_prev, lb_prev2};
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output FIFO (first-word-fall-through, registered head)
    // -----------------------------------------------------------------------
    logic [SCORE_W-1:0] mem_score_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]  mem_addr_q  [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr_q;
    logic [PW-1:0]      rd_ptr_q;
    logic [PW-1:0]      rd_next;
    logic [CNTW-1:0]    count_q, count_d;
    logic [SCORE_W-1:0] head_score_d;
    logic [ADDR_W-1:0]  head_addr_d;
    logic               overflow_d;
    logic               full;
    logic               pop;
    logic               push;
    logic               drop;

    assign out_valid = (count_q != '0);
    assign full      = (count_q == FIFO_FULL);
    assign pop       = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push      = survivor && (!full || pop);
    assign drop      = survivor && full && !pop;
    assign rd_next   = rd_ptr_q + PW'(1);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNTW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNTW'(1);
        end
    end

    // The head register tracks what mem[rd_ptr] will hold after this edge;
    // when the FIFO goes empty it keeps the last value shown.
    always_comb begin
        head_score_d = out_score;
        head_addr_d  = out_addr;
        if (count_d != '0) begin
            if ((count_q == '0) || ((count_q == CNTW'(1)) && pop)) begin
                head_score_d = center;
                head_addr_d  = center_addr;
            end else if (pop) begin
                head_score_d = mem_score_q[rd_next];
                head_addr_d  = mem_addr_q[rd_next];
            end else begin
                head_score_d = mem_score_q[rd_ptr_q];
                head_addr_d  = mem_addr_q[rd_ptr_q];
            end
        end
    end

    always_comb begin
        overflow_d = overflow;
        if (frame_start && in_valid) begin
            overflow_d = 1'b0;
        end else if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            out_score <= '0;
            out_addr  <= '0;
            overflow  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_score_q[i] <= '0;
                mem_addr_q[i]  <= '0;
            end
        end else begin
            count_q   <= count_d;
            out_score <= head_score_d;
            out_addr  <= head_addr_d;
            overflow  <= overflow_d;
            if (push) begin
                mem_score_q[wr_ptr_q] <= center;
                mem_addr_q[wr_ptr_q]  <= center_addr;
                wr_ptr_q              <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_next;
            end
        end
    end

endmodule

// File: tb/tb_fs_nms_filter.sv
module tb_fs_nms_filter;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int D  = 4;
    localparam int SW = 12;
    localparam int AW = 15;
    localparam int NPIX = W * H;

    logic          clk;
    logic          reset_n;
    logic          frame_start;
    logic          in_valid;
    logic [SW-1:0] in_score;
    logic [AW-1:0] in_addr;
    logic [SW-1:0] min_score;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] out_score;
    logic [AW-1:0] out_addr;
    logic          overflow;
    logic          frame_done;

    int checks;
    int errors;
    int fd_count;

    logic [SW-1:0] img [NPIX];
    logic [AW-1:0] q_addr[$];
    logic [SW-1:0] q_score[$];

    fs_nms_filter #(
        .IMG_W(W), .IMG_H(H), .SCORE_W(SW), .ADDR_W(AW), .FIFO_DEPTH(D)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_start(frame_start),
        .in_valid   (in_valid),
        .in_score   (in_score),
        .in_addr    (in_addr),
`ifdef FS_NMS_SCORE_THRESH_EN
        .min_score  (min_score),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_score  (out_score),
        .out_addr   (out_addr),
        .overflow   (overflow),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after posedge, so at negedge the handshake is
    // settled and the pop happens on the following posedge.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            q_addr.push_back(out_addr);
            q_score.push_back(out_score);
        end
        if (frame_done) fd_count++;
    end

    task automatic clear_img();
        for (int i = 0; i < NPIX; i++) img[i] = '0;
        q_addr.delete();
        q_score.delete();
    endtask

    task automatic send_pixel(input int idx, input bit fs);
        @(posedge clk); #1;
        in_valid    = 1'b1;
        frame_start = fs;
        in_score    = img[idx];
        in_addr     = AW'(idx);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_valid    = 1'b0;
            frame_start = 1'b0;
        end
    endtask

    task automatic send_frame(input int gap_max);
        for (int i = 0; i < NPIX; i++) begin
            if (gap_max > 0) idle_cycles($urandom_range(0, gap_max));
            send_pixel(i, i == 0);
        end
        idle_cycles(8);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || overflow !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: valid=%b ovf=%b done=%b, required 0 0 0", out_valid, overflow, frame_done);
        end
        checks++;
        if (out_score !== 12'd0 || out_addr !== 15'd0) begin
            errors++;
            $display("FAIL reset_data: score=%0d addr=%0d, required 0 0", out_score, out_addr);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_single_peak();
        int fd0;
        clear_img();
        img[19] = 12'd100;
        fd0 = fd_count;
        for (int i = 0; i < NPIX; i++) begin
            send_pixel(i, i == 0);
            if (i == 28) begin
                @(negedge clk);
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL peak_latency_pre: out_valid=%b, required 0", out_valid);
                end
            end
            if (i == 29) begin
                @(negedge clk);
                checks++;
                if (out_valid !== 1'b1 || out_addr !== 15'd19 || out_score !== 12'd100) begin
                    errors++;
                    $display("FAIL peak_latency_post: valid=%b addr=%0d score=%0d, required 1 19 100",
                             out_valid, out_addr, out_score);
                end
            end
            if (i == NPIX - 1) begin
                @(negedge clk);
                checks++;
                if (frame_done !== 1'b0) begin
                    errors++;
                    $display("FAIL frame_done_early: frame_done=%b, required 0", frame_done);
                end
            end
        end
        idle_cycles(1);
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL frame_done_pulse: frame_done=%b, required 1", frame_done);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL frame_done_width: frame_done=%b, required 0", frame_done);
        end
        idle_cycles(4);
        checks++;
        if (q_addr.size() != 1 || fd_count != fd0 + 1) begin
            errors++;
            $display("FAIL peak_count: outputs=%0d done_pulses=%0d, required 1 1", q_addr.size(), fd_count - fd0);
        end else begin
            checks++;
            if (q_addr[0] !== 15'd19 || q_score[0] !== 12'd100) begin
                errors++;
                $display("FAIL peak_value: addr=%0d score=%0d, required 19 100", q_addr[0], q_score[0]);
            end
        end
    endtask

    task automatic test_plateau();
        clear_img();
        img[18] = 12'd50;
        img[19] = 12'd50;
        send_frame(0);
        checks++;
        if (q_addr.size() != 1) begin
            errors++;
            $display("FAIL plateau_pair_count: outputs=%0d, required 1", q_addr.size());
        end else begin
            checks++;
            if (q_addr[0] !== 15'd18 || q_score[0] !== 12'd50) begin
                errors++;
                $display("FAIL plateau_pair_value: addr=%0d score=%0d, required 18 50", q_addr[0], q_score[0]);
            end
        end
        clear_img();
        for (int r = 2; r <= 4; r++)
            for (int c = 2; c <= 4; c++)
                img[r * W + c] = 12'd70;
        send_frame(0);
        checks++;
        if (q_addr.size() != 1) begin
            errors++;
            $display("FAIL plateau_block_count: outputs=%0d, required 1", q_addr.size());
        end else begin
            checks++;
            if (q_addr[0] !== 15'd18 || q_score[0] !== 12'd70) begin
                errors++;
                $display("FAIL plateau_block_value: addr=%0d score=%0d, required 18 70", q_addr[0], q_score[0]);
            end
        end
    endtask

    task automatic test_border();
        clear_img();
        img[4]  = 12'd200;
        img[42] = 12'd200;
        img[16] = 12'd200;
        img[23] = 12'd200;
        send_frame(0);
        checks++;
        if (q_addr.size() != 0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL border: outputs=%0d overflow=%b, required 0 0", q_addr.size(), overflow);
        end
    endtask

    task automatic test_overflow();
        logic [AW-1:0] exp_a [4];
        clear_img();
        exp_a[0] = 15'd9;  exp_a[1] = 15'd11;
        exp_a[2] = 15'd13; exp_a[3] = 15'd25;
        img[9]  = 12'd10; img[11] = 12'd20; img[13] = 12'd30;
        img[25] = 12'd40; img[27] = 12'd50; img[29] = 12'd60;
        out_ready = 1'b0;
        send_frame(0);
        checks++;
        if (out_valid !== 1'b1 || overflow !== 1'b1 || out_addr !== 15'd9 || out_score !== 12'd10) begin
            errors++;
            $display("FAIL ovf_full: valid=%b ovf=%b head=%0d/%0d, required 1 1 9/10",
                     out_valid, overflow, out_addr, out_score);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        idle_cycles(8);
        checks++;
        if (q_addr.size() != 4) begin
            errors++;
            $display("FAIL ovf_drain_count: outputs=%0d, required 4", q_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (q_addr[i] !== exp_a[i] || q_score[i] !== SW'((i + 1) * 10)) begin
                    errors++;
                    $display("FAIL ovf_drain_%0d: addr=%0d score=%0d, required %0d %0d",
                             i, q_addr[i], q_score[i], exp_a[i], (i + 1) * 10);
                end
            end
        end
        checks++;
        if (out_valid !== 1'b0 || overflow !== 1'b1 || out_addr !== 15'd25 || out_score !== 12'd40) begin
            errors++;
            $display("FAIL ovf_empty_hold: valid=%b ovf=%b head=%0d/%0d, required 0 1 25/40",
                     out_valid, overflow, out_addr, out_score);
        end
        send_pixel(0, 1'b1);
        idle_cycles(1);
        @(negedge clk);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: overflow=%b, required 0", overflow);
        end
    endtask

    task automatic test_gaps();
        clear_img();
        img[19] = 12'd100;
        send_frame(3);
        checks++;
        if (q_addr.size() != 1) begin
            errors++;
            $display("FAIL gaps_count: outputs=%0d, required 1", q_addr.size());
        end else begin
            checks++;
            if (q_addr[0] !== 15'd19 || q_score[0] !== 12'd100) begin
                errors++;
                $display("FAIL gaps_value: addr=%0d score=%0d, required 19 100", q_addr[0], q_score[0]);
            end
        end
    endtask

    task automatic test_midframe_reset();
        clear_img();
        img[10] = 12'd90;
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) send_pixel(i, i == 0);
        idle_cycles(1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_addr !== 15'd10) begin
            errors++;
            $display("FAIL rst_precond: valid=%b addr=%0d, required 1 10", out_valid, out_addr);
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_score !== 12'd0 || out_addr !== 15'd0 ||
            overflow !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: valid=%b score=%0d addr=%0d ovf=%b done=%b, required all 0",
                     out_valid, out_score, out_addr, overflow, frame_done);
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        out_ready = 1'b1;
        clear_img();
        img[19] = 12'd100;
        send_frame(0);
        checks++;
        if (q_addr.size() != 1) begin
            errors++;
            $display("FAIL rst_recover_count: outputs=%0d, required 1", q_addr.size());
        end else begin
            checks++;
            if (q_addr[0] !== 15'd19 || q_score[0] !== 12'd100) begin
                errors++;
                $display("FAIL rst_recover_value: addr=%0d score=%0d, required 19 100", q_addr[0], q_score[0]);
            end
        end
    endtask

`ifdef FS_NMS_SCORE_THRESH_EN
    task automatic test_thresh();
        clear_img();
        img[18] = 12'd79;
        img[29] = 12'd80;
        min_score = 12'd80;
        send_frame(0);
        checks++;
        if (q_addr.size() != 1) begin
            errors++;
            $display("FAIL thresh_count: outputs=%0d, required 1", q_addr.size());
        end else begin
            checks++;
            if (q_addr[0] !== 15'd29 || q_score[0] !== 12'd80) begin
                errors++;
                $display("FAIL thresh_value: addr=%0d score=%0d, required 29 80", q_addr[0], q_score[0]);
            end
        end
        min_score = 12'd0;
    endtask
`endif

    initial begin
        checks      = 0;
        errors      = 0;
        fd_count    = 0;
        frame_start = 1'b0;
        in_valid    = 1'b0;
        in_score    = '0;
        in_addr     = '0;
        min_score   = '0;
        out_ready   = 1'b1;
        test_reset();
        test_single_peak();
        test_plateau();
        test_border();
        test_overflow();
        test_gaps();
        test_midframe_reset();
`ifdef FS_NMS_SCORE_THRESH_EN
        test_thresh();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fs_nms_filter.md
Name: fs_nms_filter

Overview:
- Downstream stage of the FAST score datapath. Consumes the raster-ordered stream of 12-bit corner scores with their 15-bit pixel addresses.
- Applies 3x3 non-maximum suppression using two score line buffers.
- Queues surviving corners (address, score) in a small output FIFO for the host/feature-list writer.

Parameters:
- IMG_W, 180, pixels per line (>= 3)
- IMG_H, 120, lines per frame (>= 3)
- SCORE_W, 12, score width
- ADDR_W, 15, pixel address width
- FIFO_DEPTH, 16, output FIFO entries (power of 2, >= 2)

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- frame_start  in  1  pulse, coincident with first pixel (row 0, col 0) of a frame
- in_valid  in  1  in_score/in_addr valid this cycle
- in_score  in  SCORE_W  score from datapath; 0 = not a corner
- in_addr  in  ADDR_W  address of in_score pixel
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer pops head when out_valid & out_ready
- out_score  out  SCORE_W  head entry score
- out_addr  out  ADDR_W  head entry address
- overflow  out  1  sticky: a survivor was dropped on full FIFO
- frame_done  out  1  one-cycle pulse after last center of the frame is evaluated

Behaviour:
- Reset (async, reset_n=0): row/col counters 0, line buffers and window regs 0, FIFO empty. out_valid=0, out_score=0, out_addr=0, overflow=0, frame_done=0. Reset mid-frame discards all state; the next frame_start starts cleanly.
- Counters: col/row advance only on in_valid.
  - col wraps IMG_W-1 -> 0 and increments row.
  - frame_start with in_valid forces col=0, row=0 for that pixel; it also clears overflow and the frame-active state.
  - Pixels with row >= IMG_H are ignored until the next frame_start.
  - in_valid gaps (any length) do not change results.
- Window: each accepted pixel (r,c) shifts into a 3x3 score window fed by two line buffers of IMG_W entries. The center is pixel (r-1,c-1).
- Evaluation is on an accepted pixel with r>=2 and c>=2. Centers on row 0, row IMG_H-1, col 0 or col IMG_W-1 are never emitted. There is no evaluation across the line wrap.
- Survivor rule: center S>0, and S > each of the 4 raster-earlier neighbours (NW, N, NE, W), and S >= each of the 4 later neighbours (E, SW, S, SE). Exactly one pixel of a plateau survives: the first in raster order.
- Center address = in_addr - IMG_W - 1, modulo 2^ADDR_W, taken from the triggering pixel.
- Latency: a survivor is written into the FIFO on the clock edge after the triggering in_valid. out_valid asserts the following cycle if the FIFO was empty.
- FIFO is first-word-fall-through: out_score/out_addr show the head while out_valid=1 and hold their last value when empty.
- Simultaneous push and pop is allowed at any occupancy, including full, with no drop when full and popping.
- Push when full and not popping: the entry is dropped, overflow is set and held until frame_start or reset.
- frame_done: pulses one cycle after pixel (IMG_H-1, IMG_W-1) is accepted. This is the same cycle that pixel's center result is written.
- Arithmetic: comparisons unsigned SCORE_W. No saturation is needed.

Optional Feature:
- Macro: FS_NMS_SCORE_THRESH_EN.
- Defined: adds input min_score [SCORE_W-1:0]. Survivors also require S >= min_score. min_score is sampled at frame_start and held for the frame.
- Undefined: no port; any S>0 meeting the NMS rule survives.

Test Plan:
Bench uses IMG_W=8, IMG_H=6, FIFO_DEPTH=4; addr = row*8+col; out_ready=1 unless stated.
- Single peak: score 100 at (2,3), all else 0 -> exactly one output, addr 19, score 100, written the edge after addr 28 accepted; frame_done pulses after addr 47.
- Plateau: score 50 at (2,2) and (2,3) -> only addr 18 score 50; a 3x3 block of 70 centered at (3,3) -> only addr 18 (the block's NW corner).
- Border: score 200 at (0,4), (5,2), (2,0), (2,7) -> no outputs, overflow 0.
- Overflow: out_ready=0, 6 isolated peaks (scores 10..60) at interior positions -> 4 entries held, overflow=1. Then out_ready=1 -> the first 4 drain in raster order, out_valid drops. The next frame_start clears overflow.
- Gaps and reset: repeat the single-peak frame with random in_valid gaps -> identical output. reset_n low after 20 pixels -> all outputs 0 immediately; a new frame then gives the correct single result.
- FS_NMS_SCORE_THRESH_EN: min_score=80, isolated peaks 79 at addr 18 and 80 at addr 29 -> only addr 29 is output.
